debug_frame_streamer: RTL and testbench

- MIPS-side responder of the debug request/capture protocol.
- Accepts a one-cycle 6-bit request select from the MicroBlaze debug interface and snapshots the addressed source: GPR, PC, data/instr memory word, or a 96-bit pipeline latch strip.
- Streams the snapshot as 32-bit frames on consecutive cycles, MSB frame first, then one end-of-data cycle.
- Output feeds the interface's i_frame_from_mips / i_eod inputs directly.

---
 rtl/debug_frame_streamer.sv | 165 ++++++++++++++++
 tb/tb_debug_frame_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_streamer.sv
// Debug capture responder: snapshots a register, PC, memory word or a pipeline
// latch strip on request and streams it MSB-first as frames, then one EOD cycle.
module debug_frame_streamer #(
    parameter int NB_FRAME       = 32,
    parameter int NB_STRIP       = 96,
    parameter int N_STRIP_FRAMES = NB_STRIP / NB_FRAME,
    parameter int NB_SEL         = 6
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_SEL-1:0]   i_request_select,
    output logic [4:0]          o_reg_addr,
    input  logic [NB_FRAME-1:0] i_reg_data,
    input  logic [NB_FRAME-1:0] i_pc,
    input  logic [NB_FRAME-1:0] i_data_mem_data,
    input  logic [NB_FRAME-1:0] i_instr_mem_data,
    input  logic [NB_STRIP-1:0] i_latch_fetch_data,
    input  logic [NB_STRIP-1:0] i_latch_fetch_ctrl,
    input  logic [NB_STRIP-1:0] i_latch_deco_data,
    input  logic [NB_STRIP-1:0] i_latch_deco_ctrl,
    input  logic [NB_STRIP-1:0] i_latch_exec_data,
    input  logic [NB_STRIP-1:0] i_latch_exec_ctrl,
    input  logic [NB_STRIP-1:0] i_latch_mem_data,
    input  logic [NB_STRIP-1:0] i_latch_mem_ctrl,
    output logic [NB_FRAME-1:0] o_frame,
    output logic                o_eod,
    output logic                o_busy
);

    localparam int NB_PAD = NB_STRIP - NB_FRAME;
    localparam logic [1:0] STRIP_COUNT = 2'(N_STRIP_FRAMES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] EOD  = 2'd2;

    logic [1:0]          state_r, state_next_s;
    logic [NB_STRIP-1:0] buffer_r, buffer_s;
    logic [1:0]          frames_left_r, frames_left_s;
    logic [NB_FRAME-1:0] frame_r, frame_s;
    logic                eod_r, eod_s;

    logic [NB_STRIP-1:0] load_s;
    logic [1:0]          count_s;
    logic                known_s;
    logic                none_s;

    assign o_reg_addr = i_request_select[4:0];

    // Request decode: source word/strip, frame count, and known/none classification
    always_comb begin
        load_s  = {NB_STRIP{1'b0}};
        count_s = 2'd0;
        known_s = 1'b0;
        none_s  = 1'b0;
        if (i_request_select[5] == 1'b0) begin
            load_s  = {i_reg_data, {NB_PAD{1'b0}}};
            count_s = 2'd1;
            known_s = 1'b1;
        end else begin
            case (i_request_select[4:0])
                5'b00000: begin load_s = {i_data_mem_data,  {NB_PAD{1'b0}}}; count_s = 2'd1; known_s = 1'b1; end
                5'b00001: begin load_s = {i_instr_mem_data, {NB_PAD{1'b0}}}; count_s = 2'd1; known_s = 1'b1; end
                5'b00010: begin load_s = {i_pc,             {NB_PAD{1'b0}}}; count_s = 2'd1; known_s = 1'b1; end
                5'b00100: begin load_s = i_latch_fetch_data; count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b00101: begin load_s = i_latch_fetch_ctrl; count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b00110: begin load_s = i_latch_deco_data;  count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b00111: begin load_s = i_latch_deco_ctrl;  count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b01000: begin load_s = i_latch_exec_data;  count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b01001: begin load_s = i_latch_exec_ctrl;  count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b01010: begin load_s = i_latch_mem_data;   count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b01011: begin load_s = i_latch_mem_ctrl;   count_s = STRIP_COUNT; known_s = 1'b1; end
                5'b11111: none_s = 1'b1;
                default:  known_s = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; unknown codes skip straight to the EOD cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (known_s) begin
                    state_next_s = SEND;
                end else if (!none_s) begin
                    state_next_s = EOD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (frames_left_r > 2'd1) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = EOD;
                end
            end
            EOD:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath next values: snapshot on acceptance, then shift MSB-first
    always_comb begin
        buffer_s      = buffer_r;
        frames_left_s = frames_left_r;
        frame_s       = {NB_FRAME{1'b0}};
        eod_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (known_s) begin
                    buffer_s      = load_s;
                    frames_left_s = count_s;
                    frame_s       = load_s[NB_STRIP-1 -: NB_FRAME];
                end else if (!none_s) begin
                    eod_s = 1'b1;
                end else begin
                    eod_s = 1'b0;
                end
            end
            SEND: begin
                if (frames_left_r > 2'd1) begin
                    buffer_s      = buffer_r << NB_FRAME;
                    frame_s       = buffer_r[NB_STRIP-NB_FRAME-1 -: NB_FRAME];
                    frames_left_s = frames_left_r - 2'd1;
                end else begin
                    frames_left_s = 2'd0;
                    eod_s         = 1'b1;
                end
            end
            EOD:     eod_s = 1'b0;
            default: eod_s = 1'b0;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            buffer_r      <= {NB_STRIP{1'b0}};
            frames_left_r <= 2'd0;
            frame_r       <= {NB_FRAME{1'b0}};
            eod_r         <= 1'b0;
        end else begin
            buffer_r      <= buffer_s;
            frames_left_r <= frames_left_s;
            frame_r       <= frame_s;
            eod_r         <= eod_s;
        end
    end

    assign o_frame = frame_r;
    assign o_eod   = eod_r;
    assign o_busy  = (state_r != IDLE);

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Scoreboard bench for debug_frame_streamer: a request-level model pushes the
// expected frame/EOD sequence, a negedge monitor compares every busy cycle.
module tb_debug_frame_streamer;

    logic        i_clock;
    logic        i_reset;
    logic [5:0]  req;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] pc, dmem, imem;
    logic [95:0] lat [8];
    logic [31:0] frame;
    logic        eod;
    logic        busy;

    logic [31:0] regfile [32];
    logic [32:0] exp_q [$];
    int          busy_left;
    int          errors;
    int          checks;

    assign reg_data = regfile[reg_addr];

    debug_frame_streamer dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_request_select   (req),
        .o_reg_addr         (reg_addr),
        .i_reg_data         (reg_data),
        .i_pc               (pc),
        .i_data_mem_data    (dmem),
        .i_instr_mem_data   (imem),
        .i_latch_fetch_data (lat[0]),
        .i_latch_fetch_ctrl (lat[1]),
        .i_latch_deco_data  (lat[2]),
        .i_latch_deco_ctrl  (lat[3]),
        .i_latch_exec_data  (lat[4]),
        .i_latch_exec_ctrl  (lat[5]),
        .i_latch_mem_data   (lat[6]),
        .i_latch_mem_ctrl   (lat[7]),
        .o_frame            (frame),
        .o_eod              (eod),
        .o_busy             (busy)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic randomize_sources();
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        for (int i = 0; i < 8; i++) lat[i] = {$urandom, $urandom, $urandom};
        pc   = $urandom;
        dmem = $urandom;
        imem = $urandom;
    endtask

    // Reference: what a request returns, as a list of words then one EOD marker
    task automatic model_accept(input logic [5:0] sel);
        logic [95:0] snap;
        int          n;
        snap = 96'h0;
        n    = 0;
        if (sel[5] == 1'b0) begin
            snap = {regfile[sel[4:0]], 64'h0}; n = 1;
        end else if (sel == 6'd32) begin
            snap = {dmem, 64'h0}; n = 1;
        end else if (sel == 6'd33) begin
            snap = {imem, 64'h0}; n = 1;
        end else if (sel == 6'd34) begin
            snap = {pc, 64'h0}; n = 1;
        end else if (sel >= 6'd36 && sel <= 6'd43) begin
            snap = lat[sel - 6'd36]; n = 3;
        end
        for (int k = 0; k < n; k++) exp_q.push_back({1'b0, snap[95 - 32*k -: 32]});
        exp_q.push_back({1'b1, 32'h0});
        busy_left = n + 1;
    endtask

    // One request cycle: present sel, update the model, advance one clock
    task automatic step(input logic [5:0] sel);
        req = sel;
        #1;
        check("reg_addr", {28'h0, reg_addr}, {28'h0, sel[4:0]});
        if (busy_left == 0) begin
            if (sel != 6'h3F) model_accept(sel);
        end else begin
            busy_left--;
        end
        @(posedge i_clock);
        #1;
    endtask

    // Monitor: each busy cycle carries exactly one expected item; idle cycles are quiet
    always @(negedge i_clock) begin
        if (busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {eod, frame}, 33'h1_FFFF_FFFF);
            end else begin
                check("stream", {eod, frame}, exp_q.pop_front());
            end
        end else begin
            check("idle_quiet", {eod, frame}, 33'h0);
        end
    end

    initial begin
        logic [5:0] sel;
        int         r;
        errors    = 0;
        checks    = 0;
        busy_left = 0;
        randomize_sources();
        req     = 6'h3F;
        i_reset = 1'b0;

        // Reset with toggling requests
        for (int i = 0; i < 3; i++) begin
            req = (i % 2 == 0) ? 6'd5 : 6'd40;
            @(posedge i_clock);
            #1;
            check("reset_outputs", {busy, eod, frame[30:0]}, 33'h0);
        end
        i_reset = 1'b1;
        step(6'h3F);

        // Register read
        regfile[5] = 32'hDEADBEEF;
        step(6'b000101);
        randomize_sources();
        step(6'h3F);
        step(6'h3F);
        step(6'h3F);

        // Exec data strip, source changes right after acceptance
        lat[4] = 96'h111111112222222233333333;
        step(6'b101000);
        randomize_sources();
        for (int i = 0; i < 5; i++) step(6'h3F);

        // Unknown code, then PC request while a fetch strip is streaming
        step(6'b110000);
        step(6'h3F);
        step(6'h3F);
        step(6'b100100);
        step(6'b100010);
        step(6'b100010);
        for (int i = 0; i < 4; i++) step(6'h3F);

        // Async reset between frame 1 and frame 2 of a deco strip
        step(6'b100110);
        step(6'h3F);
        i_reset = 1'b0;
        #1;
        check("midstream_reset", {busy, eod, frame[30:0]}, 33'h0);
        exp_q.delete();
        busy_left = 0;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        step(6'b100010);
        for (int i = 0; i < 3; i++) step(6'h3F);

        // Back-to-back: data-mem request on the first IDLE cycle after EOD
        step(6'b100010);
        step(6'h3F);
        step(6'h3F);
        step(6'b100000);
        for (int i = 0; i < 3; i++) step(6'h3F);

        // Randomized traffic with per-cycle source changes
        for (int i = 0; i < 400; i++) begin
            randomize_sources();
            r = $urandom_range(0, 9);
            if (r < 4)      sel = 6'h3F;
            else if (r < 6) sel = 6'($urandom_range(36, 43));
            else            sel = 6'($urandom_range(0, 63));
            step(sel);
        end

        for (int i = 0; i < 8; i++) step(6'h3F);
        check("queue_drained", 33'(exp_q.size()), 33'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
